// File: rtl/hv_sram_responder.sv
// Responder for the hypervector SRAM request/return protocol.
// Read requests arrive on addr/addr_valid/addr_ready. The stored hypervectors
// return in request order on hvout/hvout_valid/hvout_ready. A load port fills
// the memory and always wins over a read in the same cycle.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   addr, addr_valid, addr_ready  read request channel
//   hvout, hvout_valid, hvout_ready  return channel (hvout is zero when idle)
//   load_addr, load_data, load_valid, load_ready  write channel
//   mem_ce, mem_we, mem_addr, mem_wdata, mem_rdata  single-port SRAM macro
module hv_sram_responder #(
    parameter int unsigned num_entry    = 32,
    parameter int unsigned addr_width   = $clog2(num_entry),
    parameter int unsigned hv_width     = 64,
    parameter int unsigned read_latency = 1,
    parameter int unsigned fifo_depth   = read_latency + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [addr_width-1:0] addr,
    input  logic                  addr_valid,
    output logic                  addr_ready,
    output logic [hv_width-1:0]   hvout,
    output logic                  hvout_valid,
    input  logic                  hvout_ready,
    input  logic [addr_width-1:0] load_addr,
    input  logic [hv_width-1:0]   load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [hv_width-1:0]   mem_wdata,
    input  logic [hv_width-1:0]   mem_rdata
);

    localparam int unsigned occ_width = $clog2(fifo_depth + 1);
    localparam int unsigned ptr_width = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [occ_width-1:0] occ_max  = occ_width'(fifo_depth);
    localparam logic [ptr_width-1:0] ptr_last = ptr_width'(fifo_depth - 1);

    logic [occ_width-1:0]    occ;
    logic [read_latency-1:0] pipe_valid;
    logic [read_latency-1:0] pipe_zero;
    logic [hv_width-1:0]     fifo_mem [fifo_depth];
    logic [ptr_width-1:0]    wr_ptr;
    logic [ptr_width-1:0]    rd_ptr;
    logic [occ_width-1:0]    fifo_count;

    logic addr_fire;
    logic hvout_fire;
    logic addr_in_range;
    logic load_in_range;
    logic push;
    logic [hv_width-1:0] push_data;

    assign addr_in_range = 32'(addr) < num_entry;
    assign load_in_range = 32'(load_addr) < num_entry;

    // Handshakes; a pop this cycle frees a slot for a new request.
    assign load_ready  = !rst;
    assign addr_ready  = !rst && !load_valid &&
                         ((occ < occ_max) || (hvout_ready && hvout_valid));
    assign addr_fire   = addr_valid && addr_ready;
    assign hvout_valid = (fifo_count != '0);
    assign hvout_fire  = hvout_valid && hvout_ready;
    assign hvout       = hvout_valid ? fifo_mem[rd_ptr] : '0;

    // Macro drive: loads take priority, out-of-range accesses leave the macro idle.
    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr;
        mem_wdata = load_data;
        if (!rst && load_valid) begin
            mem_addr = load_addr;
            if (load_in_range) begin
                mem_ce = 1'b1;
                mem_we = 1'b1;
            end
        end else if (addr_fire && addr_in_range) begin
            mem_ce = 1'b1;
        end
    end

    // Outstanding reads: in the pipeline plus held in the return buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({addr_fire, hvout_fire})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Read pipeline aligned to the macro latency; zero flag marks out-of-range reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_zero  <= '0;
        end else begin
            for (int i = read_latency - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_zero[i]  <= pipe_zero[i-1];
            end
            pipe_valid[0] <= addr_fire;
            pipe_zero[0]  <= !addr_in_range;
        end
    end

    assign push      = pipe_valid[read_latency-1];
    assign push_data = pipe_zero[read_latency-1] ? '0 : mem_rdata;

    // Return buffer storage; contents are qualified by fifo_count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // Return buffer pointers and fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == ptr_last) ? '0 : wr_ptr + 1'b1;
            end
            if (hvout_fire) begin
                rd_ptr <= (rd_ptr == ptr_last) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, hvout_fire})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_sram_responder.sv
// Bench for hv_sram_responder: instance 0 uses read_latency=1, instance 1 uses
// read_latency=3. Each has a behavioural SRAM macro. Expected returns are pushed
// at request fire and compared by a monitor on each return handshake.
module tb_hv_sram_responder;

    localparam int NE = 32;
    localparam int AW = 6;
    localparam int HW = 64;

    typedef struct {
        logic [HW-1:0] d;
        int            cyc;
        bit            exact;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [AW-1:0] addr        [2];
    logic          addr_valid  [2];
    logic          addr_ready  [2];
    logic [HW-1:0] hvout       [2];
    logic          hvout_valid [2];
    wire           hvout_ready [2];
    logic [AW-1:0] load_addr   [2];
    logic [HW-1:0] load_data   [2];
    logic          load_valid  [2];
    logic          load_ready  [2];
    logic          mem_ce      [2];
    logic          mem_we      [2];
    logic [AW-1:0] mem_addr    [2];
    logic [HW-1:0] mem_wdata   [2];
    logic [HW-1:0] mem_rdata   [2];

    int            rdy_mode [2];
    logic          rnd_bit  [2];
    logic [HW-1:0] ref_mem  [2][NE];
    int            head_cyc [2];
    int            max_occ  [2];
    exp_t          q0[$];
    exp_t          q1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned RLG = (g == 0) ? 1 : 3;
        logic [HW-1:0] macro_arr [NE];
        logic [HW-1:0] rd_pipe   [RLG];

        assign hvout_ready[g] = (rdy_mode[g] == 2) ? rnd_bit[g] : (rdy_mode[g] == 1);

        hv_sram_responder #(
            .num_entry(NE), .addr_width(AW), .hv_width(HW),
            .read_latency(RLG), .fifo_depth(RLG + 1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .addr(addr[g]), .addr_valid(addr_valid[g]), .addr_ready(addr_ready[g]),
            .hvout(hvout[g]), .hvout_valid(hvout_valid[g]), .hvout_ready(hvout_ready[g]),
            .load_addr(load_addr[g]), .load_data(load_data[g]),
            .load_valid(load_valid[g]), .load_ready(load_ready[g]),
            .mem_ce(mem_ce[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // Behavioural macro: write lands at the edge, read data appears RLG cycles later.
        always @(posedge clk) begin
            if (mem_ce[g] && mem_we[g] && (32'(mem_addr[g]) < NE))
                macro_arr[int'(mem_addr[g])] <= mem_wdata[g];
            if (mem_ce[g] && !mem_we[g] && (32'(mem_addr[g]) < NE))
                rd_pipe[0] <= macro_arr[int'(mem_addr[g])];
            else
                rd_pipe[0] <= 64'hDEAD_BEEF_5A5A_A5A5;
            for (int i = 1; i < int'(RLG); i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign mem_rdata[g] = rd_pipe[RLG-1];
    end

    function automatic int rl(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic void chk(string nm, logic [HW-1:0] act, logic [HW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic int q_size(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void q_push(int k, exp_t e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic exp_t q_pop(int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic logic [HW-1:0] exp_data(int k, int a);
        return (a < NE) ? ref_mem[k][a] : '0;
    endfunction

    // Random back-pressure source, changes just after the active edge.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) rnd_bit[k] = ($urandom % 3) != 0;
    end

    // Track the most reads ever outstanding, from the bench's own queue.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (q_size(k) > max_occ[k]) max_occ[k] = q_size(k);
    end

    // Return monitor: compare every hvout handshake against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (mem_ce[k]) chk("mem_ce_in_range", HW'(32'(mem_addr[k]) < NE), HW'(1));
                if (hvout_valid[k]) begin
                    if (head_cyc[k] < 0) head_cyc[k] = cyc;
                    if (hvout_ready[k]) begin
                        if (q_size(k) == 0) begin
                            chk("unexpected_return_valid", HW'(1), HW'(0));
                        end else begin
                            e = q_pop(k);
                            chk("hvout_data", hvout[k], e.d);
                            chk("latency_min", HW'(head_cyc[k] >= e.cyc + rl(k) + 1), HW'(1));
                            if (e.exact)
                                chk("latency_exact", HW'(head_cyc[k] - e.cyc), HW'(rl(k) + 1));
                        end
                        head_cyc[k] = -1;
                    end
                end else begin
                    chk("hvout_zero_when_idle", hvout[k], '0);
                end
            end
        end
    end

    task automatic do_load(int k, int a, logic [HW-1:0] d);
        load_addr[k]  = AW'(a);
        load_data[k]  = d;
        load_valid[k] = 1'b1;
        @(negedge clk);
        chk("load_ready", HW'(load_ready[k]), HW'(1));
        chk("load_mem_ce", HW'(mem_ce[k]), HW'(a < NE));
        if (a < NE) begin
            chk("load_mem_we", HW'(mem_we[k]), HW'(1));
            chk("load_mem_addr", HW'(mem_addr[k]), HW'(a));
            chk("load_mem_wdata", mem_wdata[k], d);
            ref_mem[k][a] = d;
        end
        @(posedge clk);
        #1 load_valid[k] = 1'b0;
    endtask

    task automatic do_read(int k, int a, bit exact);
        exp_t e;
        bit   ok = 1'b0;
        addr[k]       = AW'(a);
        addr_valid[k] = 1'b1;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (addr_ready[k]) begin
                chk("read_mem_ce", HW'(mem_ce[k]), HW'(a < NE));
                e.d = exp_data(k, a); e.cyc = cyc; e.exact = exact;
                q_push(k, e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        addr_valid[k] = 1'b0;
        if (!ok) chk("read_accept_timeout", HW'(0), HW'(1));
    endtask

    task automatic drain(int k);
        for (int n = 0; n < 600 && q_size(k) != 0; n++) @(posedge clk);
        #1;
        chk("drain_empty", HW'(q_size(k)), HW'(0));
    endtask

    initial begin
        exp_t e;
        int   stale;
        for (int k = 0; k < 2; k++) begin
            addr[k] = '0; addr_valid[k] = 1'b0; load_addr[k] = '0; load_data[k] = '0;
            load_valid[k] = 1'b0; rdy_mode[k] = 1; head_cyc[k] = -1; max_occ[k] = 0;
        end
        rst = 1'b1;
        load_valid[0] = 1'b1;
        addr_valid[0] = 1'b1;
        @(negedge clk);
        chk("rst_hvout_valid", HW'(hvout_valid[0]), HW'(0));
        chk("rst_hvout", hvout[0], '0);
        chk("rst_addr_ready", HW'(addr_ready[0]), HW'(0));
        chk("rst_load_ready", HW'(load_ready[0]), HW'(0));
        chk("rst_mem_ce", HW'(mem_ce[0]), HW'(0));
        chk("rst_mem_we", HW'(mem_we[0]), HW'(0));
        load_valid[0] = 1'b0;
        addr_valid[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill and stream-read with the return side always ready.
        for (int a = 0; a < NE; a++) do_load(0, a, {8{8'(a)}});
        for (int a = 0; a < NE; a++) do_read(0, a, 1'b1);
        drain(0);

        // Back-pressure: two accepts fill the buffer, third waits for the first pop.
        rdy_mode[0] = 0;
        do_read(0, 5, 1'b0);
        do_read(0, 6, 1'b0);
        addr[0] = AW'(7);
        addr_valid[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("bp_addr_ready_low", HW'(addr_ready[0]), HW'(0));
        end
        chk("bp_hvout_holds_head", hvout[0], ref_mem[0][5]);
        @(posedge clk);
        #1 rdy_mode[0] = 1;
        @(negedge clk);
        chk("bp_fire_with_pop", HW'(addr_ready[0]), HW'(1));
        chk("bp_head_valid", HW'(hvout_valid[0]), HW'(1));
        e.d = exp_data(0, 7); e.cyc = cyc; e.exact = 1'b0;
        q_push(0, e);
        @(posedge clk);
        #1 addr_valid[0] = 1'b0;
        drain(0);

        // Load and read to the same address in the same cycle.
        load_addr[0] = AW'(3); load_data[0] = 64'hA5A5_0123_4567_89AB; load_valid[0] = 1'b1;
        addr[0] = AW'(3); addr_valid[0] = 1'b1;
        @(negedge clk);
        chk("col_addr_ready_low", HW'(addr_ready[0]), HW'(0));
        chk("col_load_ready", HW'(load_ready[0]), HW'(1));
        chk("col_mem_we", HW'(mem_we[0]), HW'(1));
        ref_mem[0][3] = 64'hA5A5_0123_4567_89AB;
        @(posedge clk);
        #1 load_valid[0] = 1'b0;
        @(negedge clk);
        chk("col_read_fires_next", HW'(addr_ready[0]), HW'(1));
        e.d = exp_data(0, 3); e.cyc = cyc; e.exact = 1'b1;
        q_push(0, e);
        @(posedge clk);
        #1 addr_valid[0] = 1'b0;
        drain(0);

        // Out-of-range read between in-range reads, and an out-of-range load.
        do_read(0, 1, 1'b0);
        do_read(0, 40, 1'b0);
        do_read(0, 2, 1'b0);
        do_load(0, 50, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(0, 50, 1'b0);
        drain(0);

        // Reset with two reads buffered and the return side stalled.
        rdy_mode[0] = 0;
        do_read(0, 10, 1'b0);
        do_read(0, 11, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_hvout_valid", HW'(hvout_valid[0]), HW'(0));
        chk("arst_hvout", hvout[0], '0);
        chk("arst_addr_ready", HW'(addr_ready[0]), HW'(0));
        q0.delete();
        head_cyc[0] = -1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode[0] = 1;
        @(negedge clk);
        chk("post_rst_addr_ready", HW'(addr_ready[0]), HW'(1));
        stale = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (hvout_valid[0]) stale++;
        end
        chk("post_rst_no_stale", HW'(stale), HW'(0));

        // Latency-3 instance: stream with random back-pressure.
        for (int a = 0; a < NE; a++) do_load(1, a, {$urandom, $urandom});
        max_occ[1] = 0;
        rdy_mode[1] = 2;
        for (int a = 0; a < NE; a++) do_read(1, a, a == 0);
        drain(1);
        rdy_mode[1] = 1;
        chk("rl3_occ_bound", HW'(max_occ[1] <= 4), HW'(1));

        // Mixed random loads and reads on the latency-1 instance.
        max_occ[0] = 0;
        rdy_mode[0] = 2;
        for (int n = 0; n < 150; n++) begin
            if (($urandom % 5) == 0)
                do_load(0, $urandom_range(0, 39), {$urandom, $urandom});
            else
                do_read(0, $urandom_range(0, 39), 1'b0);
        end
        drain(0);
        rdy_mode[0] = 1;
        chk("rl1_occ_bound", HW'(max_occ[0] <= 2), HW'(1));

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
